// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is the I-cache, port 1 the D-cache.
package arb_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH     = 512;
    localparam int unsigned N_PORTS        = 2;

    localparam int unsigned PORT_ICACHE = 0;
    localparam int unsigned PORT_DCACHE = 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_t;

    typedef logic [N_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and axi_top-side signals of the memory port arbiter.
// The master modport is the arbiter's view; slave is the surroundings.
interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic [N_PORTS-1:0]                     i_req_read;
    logic [N_PORTS-1:0]                     i_req_write;
    logic [N_PORTS-1:0][AXI_ADDR_WIDTH-1:0] i_req_addr;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0]     i_req_data;
    logic [N_PORTS-1:0]                     o_done;
    logic [N_PORTS-1:0]                     o_grant;
    logic [DATA_WIDTH-1:0]                  o_data_read;
    logic                                   o_start_read_axi;
    logic                                   o_start_write_axi;
    logic [AXI_ADDR_WIDTH-1:0]              o_addr_axi;
    logic [DATA_WIDTH-1:0]                  o_data_write_axi;
    logic [DATA_WIDTH-1:0]                  i_data_read_axi;
    logic                                   i_read_last_axi;
    logic                                   i_b_resp_axi;

    modport master (
        input  i_req_read, i_req_write, i_req_addr, i_req_data,
        input  i_data_read_axi, i_read_last_axi, i_b_resp_axi,
        output o_done, o_grant, o_data_read,
        output o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_write_axi
    );

    modport slave (
        output i_req_read, i_req_write, i_req_addr, i_req_data,
        output i_data_read_axi, i_read_last_axi, i_b_resp_axi,
        input  o_done, o_grant, o_data_read,
        input  o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_write_axi
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did
// not win last time is granted.
module rr_pick2
    import arb_pkg::*;
(
    input  port_vec_t req,
    input  logic      last,
    output port_vec_t grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = '0;
            if (last) begin
                grant[PORT_ICACHE] = 1'b1;
            end else begin
                grant[PORT_DCACHE] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single axi_top burst path between the I-cache and D-cache,
// latching the winner's address/line and returning completion to it only.
module mem_port_arbiter
    import arb_pkg::*;
(
    input logic                clk,
    input logic                i_srst,
    mem_port_arbiter_if.master bus
);

    arb_state_t                state_q, state_d;
    logic                      rr_last_q, rr_last_d;
    port_vec_t                 grant_q, grant_d;
    port_vec_t                 done_q, done_d;
    logic                      start_rd_q, start_rd_d;
    logic                      start_wr_q, start_wr_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    port_vec_t req;
    port_vec_t pick;
    logic      win_port;

    assign req      = bus.i_req_read | bus.i_req_write;
    assign win_port = pick[PORT_DCACHE];

    rr_pick2 u_pick (
        .req   (req),
        .last  (rr_last_q),
        .grant (pick)
    );

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        done_d     = '0;
        start_rd_d = start_rd_q;
        start_wr_d = start_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    // Priority only rotates when both ports actually contended.
                    if (&req) begin
                        rr_last_d = win_port;
                    end
                    addr_d  = bus.i_req_addr[win_port];
                    wdata_d = bus.i_req_data[win_port];
                    // Write-back goes before refill so a dirty victim is never lost.
                    if (bus.i_req_write[win_port]) begin
                        start_wr_d = 1'b1;
                        state_d    = WRITE;
                    end else begin
                        start_rd_d = 1'b1;
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                if (bus.i_read_last_axi) begin
                    rdata_d    = bus.i_data_read_axi;
                    done_d     = grant_q;
                    start_rd_d = 1'b0;
                    state_d    = DONE;
                end
            end
            WRITE: begin
                if (bus.i_b_resp_axi) begin
                    done_d     = grant_q;
                    start_wr_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            grant_q    <= '0;
            done_q     <= '0;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            start_rd_q <= start_rd_d;
            start_wr_q <= start_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.o_done            = done_q;
    assign bus.o_grant           = grant_q;
    assign bus.o_data_read       = rdata_q;
    assign bus.o_start_read_axi  = start_rd_q;
    assign bus.o_start_write_axi = start_wr_q;
    assign bus.o_addr_axi        = addr_q;
    assign bus.o_data_write_axi  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: plays both caches and axi_top, predicting each
// transaction from pending requests and round-robin history.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic i_srst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk    (clk),
        .i_srst (i_srst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: what each cache is asking for and who won the last tie.
    logic [1:0]   pend_rd, pend_wr;
    logic [63:0]  addr_m [2];
    logic [511:0] data_m [2];
    logic         rr_last;
    logic [511:0] last_rdata;
    int           done_cnt [2];
    int           p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        return a & ~64'h3f;
    endfunction

    task automatic drive();
        bus.i_req_read    = pend_rd;
        bus.i_req_write   = pend_wr;
        bus.i_req_addr[0] = addr_m[0];
        bus.i_req_addr[1] = addr_m[1];
        bus.i_req_data[0] = data_m[0];
        bus.i_req_data[1] = data_m[1];
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, bus.o_grant, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_srd"}, bus.o_start_read_axi, 0);
        chk({tag, "_swr"}, bus.o_start_write_axi, 0);
        chk({tag, "_rdata"}, bus.o_data_read, last_rdata);
    endtask

    task automatic idle_step(input string tag);
        tick();
        chk_idle(tag);
    endtask

    task automatic do_reset();
        i_srst = 1'b1;
        tick();
        chk("rst_grant", bus.o_grant, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_srd", bus.o_start_read_axi, 0);
        chk("rst_swr", bus.o_start_write_axi, 0);
        chk("rst_addr", bus.o_addr_axi, 0);
        chk("rst_wdata", bus.o_data_write_axi, 0);
        chk("rst_rdata", bus.o_data_read, 0);
        i_srst     = 1'b0;
        rr_last    = 1'b1;
        last_rdata = '0;
    endtask

    // Called in an IDLE cycle with requests driven; leaves the bench in the DONE cycle.
    task automatic serve(input int gap, input bit mutate, input logic [511:0] rdata,
                         output int port);
        logic [1:0]   req, ew;
        int           w;
        bit           is_wr;
        logic [63:0]  ea;
        logic [511:0] ed;
        req = pend_rd | pend_wr;
        if (req == 2'b11) begin
            w       = rr_last ? 0 : 1;
            rr_last = (w == 1);
        end else begin
            w = req[1] ? 1 : 0;
        end
        ew    = (w == 1) ? 2'b10 : 2'b01;
        is_wr = pend_wr[w];
        ea    = addr_m[w];
        ed    = data_m[w];
        tick();
        port = bus.o_grant[1] ? 1 : 0;
        chk("grant", bus.o_grant, ew);
        chk("start_rd", bus.o_start_read_axi, !is_wr);
        chk("start_wr", bus.o_start_write_axi, is_wr);
        chk("addr", bus.o_addr_axi, ea);
        chk("wdata", bus.o_data_write_axi, ed);
        chk("done_early", bus.o_done, 0);
        for (int i = 0; i < gap; i++) begin
            if (mutate) begin
                addr_m[w] = rand_addr();
                data_m[w] = rand_line();
                drive();
            end
            // The opposite completion strobe must be ignored.
            bus.i_read_last_axi = is_wr;
            bus.i_b_resp_axi    = !is_wr;
            bus.i_data_read_axi = rand_line();
            tick();
            chk("hold_rd", bus.o_start_read_axi, !is_wr);
            chk("hold_wr", bus.o_start_write_axi, is_wr);
            chk("hold_addr", bus.o_addr_axi, ea);
            chk("hold_wdata", bus.o_data_write_axi, ed);
            chk("hold_done", bus.o_done, 0);
            chk("hold_rdata", bus.o_data_read, last_rdata);
        end
        bus.i_read_last_axi = !is_wr;
        bus.i_b_resp_axi    = is_wr;
        bus.i_data_read_axi = rdata;
        tick();
        if (!is_wr) last_rdata = rdata;
        chk("done", bus.o_done, ew);
        chk("done_grant", bus.o_grant, ew);
        chk("done_srd", bus.o_start_read_axi, 0);
        chk("done_swr", bus.o_start_write_axi, 0);
        chk("done_rdata", bus.o_data_read, last_rdata);
        done_cnt[0] += int'(bus.o_done[0]);
        done_cnt[1] += int'(bus.o_done[1]);
        bus.i_read_last_axi = 1'b0;
        bus.i_b_resp_axi    = 1'b0;
        if (is_wr) pend_wr[w] = 1'b0;
        else       pend_rd[w] = 1'b0;
        drive();
    endtask

    initial begin
        pend_rd = '0;
        pend_wr = '0;
        for (int i = 0; i < 2; i++) begin
            addr_m[i]   = '0;
            data_m[i]   = '0;
            done_cnt[i] = 0;
        end
        bus.i_data_read_axi = '0;
        bus.i_read_last_axi = 1'b0;
        bus.i_b_resp_axi    = 1'b0;
        drive();
        i_srst = 1'b1;
        tick();
        do_reset();
        idle_step("rst_idle");

        // T1: single read from port 0
        addr_m[0]  = 64'h1000;
        pend_rd[0] = 1'b1;
        drive();
        serve(1, 0, {64{8'hAB}}, p);
        chk("t1_port", p, 0);
        idle_step("t1_idle");

        // T2: tie on reads, port 0 first, port 1 two cycles after completion
        addr_m[0] = 64'h2000;
        addr_m[1] = 64'h3000;
        pend_rd   = 2'b11;
        drive();
        serve(0, 0, rand_line(), p);
        chk("t2_first", p, 0);
        idle_step("t2_idle0");
        serve(2, 0, rand_line(), p);
        chk("t2_second", p, 1);
        idle_step("t2_idle1");

        // T3: port 1 read+write together, write first, same address
        addr_m[1]  = 64'h4000;
        data_m[1]  = {64{8'h5A}};
        pend_rd[1] = 1'b1;
        pend_wr[1] = 1'b1;
        drive();
        serve(1, 0, rand_line(), p);
        chk("t3_rd_pending", pend_rd[1], 1);
        idle_step("t3_idle0");
        serve(1, 0, rand_line(), p);
        idle_step("t3_idle1");

        // T4: saturating requests alternate 0,1,0,1,0,1
        pend_rd = '0;
        pend_wr = '0;
        drive();
        do_reset();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        pend_rd     = 2'b11;
        pend_wr     = 2'($urandom_range(3, 0));
        addr_m[0]   = rand_addr();
        addr_m[1]   = rand_addr();
        data_m[0]   = rand_line();
        data_m[1]   = rand_line();
        drive();
        for (int i = 0; i < 6; i++) begin
            serve($urandom_range(2, 0), 0, rand_line(), p);
            chk("t4_order", p, i % 2);
            if ($urandom_range(1, 0) == 1) pend_wr[p] = 1'b1;
            else                            pend_rd[p] = 1'b1;
            drive();
            idle_step("t4_idle");
        end
        chk("t4_done0", done_cnt[0], 3);
        chk("t4_done1", done_cnt[1], 3);

        // T5: reset in the middle of a read, then normal service
        pend_rd = '0;
        pend_wr = '0;
        drive();
        do_reset();
        addr_m[0]  = 64'h5000;
        pend_rd[0] = 1'b1;
        drive();
        tick();
        chk("t5_srd", bus.o_start_read_axi, 1);
        tick();
        do_reset();
        serve(1, 0, rand_line(), p);
        chk("t5_port", p, 0);
        idle_step("t5_idle");

        // T6: port 0 rewrites its address/data during its write
        addr_m[0]  = 64'h6000;
        data_m[0]  = rand_line();
        pend_wr[0] = 1'b1;
        drive();
        serve(3, 1, rand_line(), p);
        chk("t6_port", p, 0);
        idle_step("t6_idle");

        // Random traffic against the reference
        for (int n = 0; n < 40; n++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend_rd[q] && !pend_wr[q]) begin
                    addr_m[q] = rand_addr();
                    data_m[q] = rand_line();
                end
                if ($urandom_range(2, 0) == 0) pend_rd[q] = 1'b1;
                if ($urandom_range(2, 0) == 0) pend_wr[q] = 1'b1;
            end
            drive();
            if ((pend_rd | pend_wr) == 2'b00) begin
                idle_step("rnd_noreq");
            end else begin
                serve($urandom_range(3, 0), $urandom_range(1, 0) == 1, rand_line(), p);
                idle_step("rnd_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
